// File: rtl/data_mem_ctrl.sv
// Load/store data memory controller: one request in flight, fixed wait states, byte/half/word lanes.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses with rsp_err.
module data_mem_ctrl #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         AW        = IDX_W + 2;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    logic [31:0] mem_array [0:DEPTH-1];

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic            ready_r, valid_r, err_r;
    logic [31:0]     rdata_r;
    logic            we_r, uns_r;
    logic [AW-1:0]   addr_r;
    logic [1:0]      size_r;
    logic [31:0]     wdata_r;
    logic            accept_s, enter_resp_s;
    logic            acc_we_s, acc_uns_s;
    logic [AW-1:0]   acc_addr_s;
    logic [1:0]      acc_size_s;
    logic [31:0]     acc_wdata_s;
    logic [IDX_W-1:0] acc_idx_s;
    logic [31:0]     word_s, wr_word_s, load_s;
    logic            err_s, wr_en_s;
    logic            unused_addr_s;

    assign unused_addr_s = ^req_addr[31:AW];

    function automatic logic [31:0] store_merge(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] w;
        w = old_word;
        case (size)
            2'b00:   w[{lane, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   w[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

`ifdef DMEM_ALIGN_CHECK_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        logic m;
        case (size)
            2'b00:   m = 1'b0;
            2'b01:   m = lane[0];
            default: m = (lane != 2'b00);
        endcase
        return m;
    endfunction
`endif

    // Next-state and counter logic for the IDLE/WAIT/RESP handshake.
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (req_valid && ready_r) begin
                    accept_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_s      = RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_s = WAIT;
                        cnt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                cnt_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_s      = RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = RESP;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // Access datapath; with zero wait states the access uses the live request fields.
    always_comb begin
        acc_we_s    = we_r;
        acc_uns_s   = uns_r;
        acc_addr_s  = addr_r;
        acc_size_s  = size_r;
        acc_wdata_s = wdata_r;
        if (state_r == IDLE) begin
            acc_we_s    = req_we;
            acc_uns_s   = req_unsigned;
            acc_addr_s  = req_addr[AW-1:0];
            acc_size_s  = req_size;
            acc_wdata_s = req_wdata;
        end else begin
            acc_we_s    = we_r;
        end
        acc_idx_s = acc_addr_s[AW-1:2];
        word_s    = mem_array[acc_idx_s];
`ifdef DMEM_ALIGN_CHECK_EN
        err_s = misaligned(acc_size_s, acc_addr_s[1:0]);
`else
        err_s = 1'b0;
`endif
        wr_en_s   = enter_resp_s && acc_we_s && !err_s;
        wr_word_s = store_merge(word_s, acc_wdata_s, acc_size_s, acc_addr_s[1:0]);
        if (err_s || acc_we_s) begin
            load_s = 32'd0;
        end else begin
            load_s = load_extend(word_s, acc_size_s, acc_addr_s[1:0], acc_uns_s);
        end
    end

    // State, captured request and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
            uns_r   <= 1'b0;
            addr_r  <= '0;
            size_r  <= 2'b00;
            wdata_r <= 32'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ready_r <= (state_s == IDLE);
            valid_r <= (state_s == RESP);
            if (accept_s) begin
                we_r    <= req_we;
                uns_r   <= req_unsigned;
                addr_r  <= req_addr[AW-1:0];
                size_r  <= req_size;
                wdata_r <= req_wdata;
            end
            if (enter_resp_s) begin
                rdata_r <= load_s;
                err_r   <= err_s;
            end
        end
    end

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_array[acc_idx_s] <= wr_word_s;
        end
    end

    assign req_ready = ready_r;
    assign rsp_valid = valid_r;
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: dut 0 uses WAIT_CYCLES=2, dut 1 uses WAIT_CYCLES=0.
// Drivers push expected responses; a negedge monitor pops and compares them.
module tb_data_mem_ctrl;
    localparam int W0 = 2;
    localparam int W1 = 0;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  hold;
        logic [31:0] acc;
    } exp_t;

    logic        tb_clk = 1'b0;
    logic        rst    = 1'b1;
    logic [1:0]  req_valid    = 2'b00;
    logic [1:0]  req_we       = 2'b00;
    logic [1:0]  req_unsigned = 2'b00;
    logic [1:0]  rsp_ready    = 2'b00;
    logic [31:0] req_addr  [2];
    logic [1:0]  req_size  [2];
    logic [31:0] req_wdata [2];
    wire  [1:0]  req_ready;
    wire  [1:0]  rsp_valid;
    wire  [1:0]  rsp_err;
    wire  [31:0] rsp_rdata [2];

    int   compared = 0;
    int   errors   = 0;
    int   ncyc     = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    bit   seen   [2];
    int   hcnt   [2];
    int   hs_cyc [2];

    data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(W0)) u0 (
        .clk(tb_clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    data_mem_ctrl #(.DEPTH(256), .WAIT_CYCLES(W1)) u1 (
        .clk(tb_clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) ncyc <= ncyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    function automatic int qsz(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Monitor: latency and data on rise, stability while held, pop on handshake.
    task automatic mon_step(input int d);
        exp_t e;
        int   lat;
        if (rsp_valid[d]) begin
            if (qsz(d) == 0) begin
                compared++;
                errors++;
                $display("FAIL unexpected_rsp dut%0d: got rdata %h expected no response", d, rsp_rdata[d]);
                rsp_ready[d] = 1'b1;
                return;
            end
            e   = qfront(d);
            lat = ((d == 0) ? W0 : W1) + 1;
            if (!seen[d]) begin
                seen[d] = 1'b1;
                hcnt[d] = int'(e.hold);
                chk($sformatf("latency_dut%0d", d), ncyc - int'(e.acc), lat);
                chk($sformatf("rdata_dut%0d", d), rsp_rdata[d], e.rdata);
                chk($sformatf("err_dut%0d", d), {31'd0, rsp_err[d]}, {31'd0, e.err});
            end else begin
                chk($sformatf("rdata_stable_dut%0d", d), rsp_rdata[d], e.rdata);
            end
            chk($sformatf("ready_in_resp_dut%0d", d), {31'd0, req_ready[d]}, 32'd0);
            if (hcnt[d] == 0) begin
                rsp_ready[d] = 1'b1;
                hs_cyc[d]    = ncyc;
                qpop(d);
                seen[d]      = 1'b0;
            end else begin
                rsp_ready[d] = 1'b0;
                hcnt[d]      = hcnt[d] - 1;
            end
        end else begin
            rsp_ready[d] = 1'b0;
        end
    endtask

    always @(negedge tb_clk) begin
        mon_step(0);
        mon_step(1);
    end

    // Called at a negedge; returns at the negedge after the accept edge with the inputs scrambled.
    task automatic issue(input int d, input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata, input logic [31:0] er,
                         input logic ee, input int hold, input bit push, output int acc);
        exp_t e;
        int   n = 0;
        req_valid[d] = 1'b1;
        req_we[d] = we; req_addr[d] = addr; req_size[d] = size;
        req_unsigned[d] = uns; req_wdata[d] = wdata;
        while (!req_ready[d] && n < 100) begin
            @(negedge tb_clk);
            n++;
        end
        if (!req_ready[d]) begin
            chk($sformatf("accept_timeout_dut%0d", d), 32'd0, 32'd1);
            req_valid[d] = 1'b0;
            acc = -1;
            return;
        end
        acc = ncyc;
        if (push) begin
            e.rdata = er; e.err = ee; e.hold = 8'(hold); e.acc = 32'(acc);
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge tb_clk);
        req_valid[d] = 1'b0;
        req_we[d] = ~we; req_addr[d] = ~addr; req_size[d] = ~size;
        req_unsigned[d] = ~uns; req_wdata[d] = ~wdata;
    endtask

    task automatic drain(input int d);
        int n = 0;
        while ((qsz(d) != 0 || rsp_valid[d]) && n < 200) begin
            @(negedge tb_clk);
            n++;
        end
        if (qsz(d) != 0 || rsp_valid[d]) chk($sformatf("drain_timeout_dut%0d", d), 32'd0, 32'd1);
    endtask

    initial begin
        int          a, b;
        logic [31:0] mis_word;
        for (int i = 0; i < 2; i++) begin
            req_addr[i] = 32'd0; req_size[i] = 2'b00; req_wdata[i] = 32'd0;
            seen[i] = 1'b0; hcnt[i] = 0; hs_cyc[i] = 0;
        end
        repeat (3) @(negedge tb_clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_req_ready_dut%0d", i), {31'd0, req_ready[i]}, 32'd0);
            chk($sformatf("rst_rsp_valid_dut%0d", i), {31'd0, rsp_valid[i]}, 32'd0);
            chk($sformatf("rst_rsp_rdata_dut%0d", i), rsp_rdata[i], 32'd0);
            chk($sformatf("rst_rsp_err_dut%0d", i), {31'd0, rsp_err[i]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge tb_clk);
        chk("ready_after_rst_dut0", {31'd0, req_ready[0]}, 32'd1);
        chk("ready_after_rst_dut1", {31'd0, req_ready[1]}, 32'd1);

        // SW 123 to addr 4, LW back
        issue(0, 1'b1, 32'd4, 2'b10, 1'b0, 32'd123, 32'd0, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'd4, 2'b10, 1'b0, 32'd0, 32'h0000007B, 1'b0, 0, 1'b1, a);
        drain(0);
        chk("mem1_after_sw", u0.mem_array[1], 32'h0000007B);

        // Byte/halfword lanes and extension
        issue(0, 1'b1, 32'd0, 2'b10, 1'b0, 32'h11223344, 32'd0, 1'b0, 0, 1'b1, a);
        issue(0, 1'b1, 32'd2, 2'b00, 1'b0, 32'h123456AA, 32'd0, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'd0, 2'b10, 1'b0, 32'd0, 32'h11AA3344, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'd2, 2'b00, 1'b0, 32'd0, 32'hFFFFFFAA, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'd2, 2'b00, 1'b1, 32'd0, 32'h000000AA, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'd2, 2'b01, 1'b0, 32'd0, 32'h000011AA, 1'b0, 0, 1'b1, a);
        issue(0, 1'b1, 32'hC, 2'b10, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b1, a);
        issue(0, 1'b1, 32'hE, 2'b01, 1'b0, 32'hBEEF8001, 32'd0, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'hE, 2'b01, 1'b0, 32'd0, 32'hFFFF8001, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'hE, 2'b01, 1'b1, 32'd0, 32'h00008001, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'hF, 2'b00, 1'b0, 32'd0, 32'hFFFFFF80, 1'b0, 0, 1'b1, a);
        issue(0, 1'b0, 32'hC, 2'b10, 1'b0, 32'd0, 32'h80010000, 1'b0, 0, 1'b1, a);

        // Backpressure: hold rsp_ready low 5 cycles, next request waiting with req_valid high
        issue(0, 1'b0, 32'd0, 2'b10, 1'b0, 32'd0, 32'h11AA3344, 1'b0, 5, 1'b1, a);
        issue(0, 1'b0, 32'd1, 2'b00, 1'b1, 32'd0, 32'h00000033, 1'b0, 0, 1'b1, b);
        chk("b2b_accept_cycle", 32'(b), 32'(hs_cyc[0] + 1));

        // Address wrap
        issue(0, 1'b0, 32'h404, 2'b10, 1'b0, 32'd0, 32'h0000007B, 1'b0, 0, 1'b1, a);
        issue(1, 1'b1, 32'h400, 2'b10, 1'b0, 32'hDEADBEEF, 32'd0, 1'b0, 0, 1'b1, a);
        drain(1);
        chk("wrap_mem0_dut1", u1.mem_array[0], 32'hDEADBEEF);
        issue(1, 1'b0, 32'd0, 2'b10, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 0, 1'b1, a);
        issue(1, 1'b0, 32'h402, 2'b01, 1'b1, 32'd0, 32'h0000DEAD, 1'b0, 1, 1'b1, a);

        // Misaligned accesses
        mis_word = ALIGN_ON ? 32'h0000007B : 32'hCAFEF00D;
        issue(0, 1'b1, 32'd6, 2'b10, 1'b0, 32'hCAFEF00D, 32'd0, ALIGN_ON, 0, 1'b1, a);
        issue(0, 1'b0, 32'd5, 2'b10, 1'b0, 32'd0, ALIGN_ON ? 32'd0 : 32'hCAFEF00D, ALIGN_ON, 0, 1'b1, a);
        issue(0, 1'b0, 32'd4, 2'b11, 1'b0, 32'd0, mis_word, 1'b0, 0, 1'b1, a);
        drain(0);
        chk("mem1_after_misaligned_sw", u0.mem_array[1], mis_word);

        // Reset during WAIT of a store
        issue(0, 1'b1, 32'd8, 2'b10, 1'b0, 32'h00000055, 32'd0, 1'b0, 0, 1'b1, a);
        issue(0, 1'b1, 32'd8, 2'b10, 1'b0, 32'h00000099, 32'd0, 1'b0, 0, 1'b0, a);
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("abort_req_ready", {31'd0, req_ready[0]}, 32'd0);
        repeat (3) @(negedge tb_clk);
        rst = 1'b0;
        @(negedge tb_clk);
        chk("ready_after_abort", {31'd0, req_ready[0]}, 32'd1);
        chk("mem2_after_abort", u0.mem_array[2], 32'h00000055);
        issue(0, 1'b0, 32'd8, 2'b10, 1'b0, 32'd0, 32'h00000055, 1'b0, 0, 1'b1, a);

        drain(0);
        drain(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit words in the internal array mem_array.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, giving the wait states (0..15) inserted between request accept and response.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-high (ports clk and rst).
REQ-004 The block SHALL have port clk, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: the core presents a load/store request.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block can accept a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-009 The block SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
REQ-011 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads (LBU/LHU), 0 = sign-extend.
REQ-012 The block SHALL have port req_wdata, input, 32 bits: store data, right-aligned (byte in [7:0], halfword in [15:0]).
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: a response is presented.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: the core accepts the response.
REQ-015 The block SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: the access was rejected (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 A request is accepted on a rising edge with req_valid=1 and req_ready=1; the block SHALL register all req_* fields at that edge.
REQ-019 On accept, IDLE SHALL go to WAIT with the counter loaded to WAIT_CYCLES, or directly to RESP if WAIT_CYCLES=0.
REQ-020 WAIT SHALL decrement the counter each cycle and enter RESP on the edge where the counter is 1; rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-021 The array write for a store and the read for a load SHALL occur on the edge entering RESP; rsp_rdata and rsp_err SHALL be registered at that edge and stay stable while in RESP.
REQ-022 RESP SHALL hold rsp_valid=1 until a rising edge with rsp_ready=1, then return to IDLE; req_ready SHALL be 1 in the following cycle.
REQ-023 A request SHALL NOT be accepted in the cycle in which a response completes: no back-to-back overlap, one transaction in flight at most.
REQ-024 The word index SHALL be req_addr[log2(DEPTH)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH*4.
REQ-025 Byte accesses SHALL use lane addr[1:0] and halfword accesses lane addr[1]*2 (little-endian); stores SHALL modify only the addressed bytes.
REQ-026 Loads SHALL sign- or zero-extend the selected byte or halfword to 32 bits according to req_unsigned; word loads SHALL return the full word.
REQ-027 Changes on req_* inputs outside the accept edge SHALL have no effect.

Reset
REQ-028 While rst=1, the FSM SHALL be in IDLE, the counter 0, req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0; req_ready SHALL become 1 in the first cycle after rst falls.
REQ-029 Reset asserted mid-transaction SHALL abort it; a store aborted before the RESP entry edge SHALL NOT write.
REQ-030 Reset SHALL NOT clear mem_array; the bench SHALL be able to preload it hierarchically with $readmemh.

Configuration
REQ-031 With macro DMEM_ALIGN_CHECK_EN defined, a halfword with addr[0]=1 or a word with addr[1:0]!=0 SHALL complete with normal timing, rsp_err=1, rsp_rdata=0 and no array write.
REQ-032 Without DMEM_ALIGN_CHECK_EN, rsp_err SHALL be tied to 0, and misaligned accesses SHALL ignore the low address bits (halfword: addr[0]; word: addr[1:0]).

Verification
REQ-033 WAIT_CYCLES=2: SW 123 to addr 4, then LW addr 4 -> rsp_valid rises 3 cycles after each accept, rsp_rdata=0x0000007B, mem_array[1]=0x0000007B.
REQ-034 Preload mem_array[0]=0x11223344: SB 0xAA to addr 2, then LW addr 0 -> 0x11AA3344; LB addr 2 -> 0xFFFFFFAA; LBU addr 2 -> 0x000000AA; LH addr 2 -> 0x000011AA.
REQ-035 Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stay stable and req_ready=0; with req_valid held at 1, the next accept occurs the cycle after the rsp_ready handshake.
REQ-036 DEPTH=256: SW 0xDEADBEEF to addr 0x400 -> mem_array[0]=0xDEADBEEF (wrap); with WAIT_CYCLES=0, rsp_valid rises 1 cycle after accept.
REQ-037 With DMEM_ALIGN_CHECK_EN, SW to addr 6 -> rsp_err=1 and the target word is unchanged; without the macro, the same SW writes mem_array[1] and rsp_err=0.
REQ-038 Assert rst during WAIT of a store to addr 8 -> rsp_valid=0 immediately, mem_array[2] is unchanged, and req_ready=1 in the first cycle after rst falls.
